// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-back slot record.
package regfile_pkg;
   localparam int REG_AW    = 5;
   localparam int REG_DW    = 32;
   localparam int NUM_REGS  = 32;
   localparam int NUM_PORTS = 2;
   localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] addr;
      logic [REG_DW-1:0] data;
   } slot_t;
endpackage

// File: rtl/wb_slot.sv
// One-entry write-back buffer. A load wins over a free in the same cycle, so a
// granted slot can be refilled without a bubble.
module wb_slot
   import regfile_pkg::*;
#(
   parameter int AW = REG_AW,
   parameter int DW = REG_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic          i_free,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_data,
   output logic          o_v,
   output logic [AW-1:0] o_addr,
   output logic [DW-1:0] o_data
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_v    <= 1'b0;
         o_addr <= '0;
         o_data <= '0;
      end else if (i_load) begin
         o_v    <= 1'b1;
         o_addr <= i_addr;
         o_data <= i_data;
      end else if (i_free) begin
         o_v    <= 1'b0;
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port write-back arbiter for the register file's single write port, with
// oldest-first ordering, round-robin tie break and a pending-write mask.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int AW = REG_AW,
   parameter int DW = REG_DW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                hold,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [AW-1:0]       req0_addr,
   input  logic [DW-1:0]       req0_data,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [AW-1:0]       req1_addr,
   input  logic [DW-1:0]       req1_data,
   output logic                we,
   output logic [AW-1:0]       waddr,
   output logic [DW-1:0]       wdata,
   output logic [NUM_REGS-1:0] pend_mask
);
   logic [NUM_PORTS-1:0]         w_valid, w_ready, w_load, w_grant, w_sv;
   logic [NUM_PORTS-1:0][AW-1:0] w_addr_in, w_saddr;
   logic [NUM_PORTS-1:0][DW-1:0] w_data_in, w_sdata;
   logic [AW-1:0]                w_gaddr;
   logic [DW-1:0]                w_gdata;
   logic                         w_both;
   logic [NUM_PORTS-1:0]         r_young;
   logic                         r_rr;

   assign w_valid   = {req1_valid, req0_valid};
   assign w_addr_in = {req1_addr, req0_addr};
   assign w_data_in = {req1_data, req0_data};
   assign req0_ready = w_ready[0];
   assign req1_ready = w_ready[1];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
      wb_slot #(.AW(AW), .DW(DW)) u_slot (
         .clk    (clk),
         .rst    (rst),
         .i_load (w_load[p]),
         .i_free (w_grant[p]),
         .i_addr (w_addr_in[p]),
         .i_data (w_data_in[p]),
         .o_v    (w_sv[p]),
         .o_addr (w_saddr[p]),
         .o_data (w_sdata[p])
      );
   end

   // Grant uses only registered state and hold: no valid->ready path.
   // r_young[p] marks slot p as loaded after the other one; neither young means a tie.
   always_comb begin
      w_grant = '0;
      if (!hold) begin
         if (w_sv[0] && (!w_sv[1] || r_young[1] || (!r_young[0] && !r_rr)))
            w_grant[0] = 1'b1;
         else if (w_sv[1])
            w_grant[1] = 1'b1;
      end
   end

   assign w_both  = &w_sv;
   assign w_ready = ~w_sv | w_grant;
   assign w_load  = w_valid & w_ready;
   assign w_gaddr = w_grant[1] ? w_saddr[1] : w_saddr[0];
   assign w_gdata = w_grant[1] ? w_sdata[1] : w_sdata[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_young <= '0;
         r_rr    <= 1'b0;
         we      <= 1'b0;
         waddr   <= '0;
         wdata   <= '0;
      end else begin
         // A load clears the other slot's stale young flag so both can never be set.
         if (w_load[0])
            r_young[0] <= w_sv[1] && !w_grant[1];
         else if (w_load[1])
            r_young[0] <= 1'b0;
         if (w_load[1])
            r_young[1] <= w_sv[0] && !w_grant[0];
         else if (w_load[0])
            r_young[1] <= 1'b0;

         if (w_both && |w_grant)
            r_rr <= w_grant[0];

         we <= 1'b0;
         if (|w_grant && (w_gaddr != AW'(ZERO_REG))) begin
            we    <= 1'b1;
            waddr <= w_gaddr;
            wdata <= w_gdata;
         end
      end
   end

   always_comb begin
      pend_mask = '0;
      for (int k = 1; k < NUM_REGS; k++)
         pend_mask[k] = (w_sv[0] && (w_saddr[0] == AW'(k))) ||
                        (w_sv[1] && (w_saddr[1] == AW'(k))) ||
                        (we && (waddr == AW'(k)));
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset-mid-burst sequence,
// then random traffic against an arrival-timestamp reference model.
module tb_regfile_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        hold;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]  req0_addr, req1_addr;
   logic [31:0] req0_data, req1_data;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] pend_mask;

   int n_err = 0;
   int n_chk = 0;
   logic [31:0] tb_rf [32];

   regfile_wb_arbiter #(.AW(5), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .hold       (hold),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .pend_mask  (pend_mask)
   );

   always #5 clk = ~clk;

   // Register file stand-in: captures on the falling edge of the we cycle.
   always @(negedge clk) if (we) tb_rf[waddr] = wdata;

   typedef struct {
      logic        hold, v0;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic        v1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        r0, r1, we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] pm;
   } vec_t;

   vec_t tbl [29];

   function automatic vec_t mk(input logic h, v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic r0, r1, w, input logic [4:0] wa,
                               input logic [31:0] wd, pm);
      vec_t t;
      t.hold = h; t.v0 = v0; t.a0 = a0; t.d0 = d0; t.v1 = v1; t.a1 = a1; t.d1 = d1;
      t.r0 = r0; t.r1 = r1; t.we = w; t.wa = wa; t.wd = wd; t.pm = pm;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 30) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic h, v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1);
      hold = h; req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
   endtask

   task automatic chk_outs(input string tag, input logic r0, r1, w, input logic [4:0] wa,
                           input logic [31:0] wd, pm);
      chk({tag, " ready0"}, 64'(req0_ready), 64'(r0));
      chk({tag, " ready1"}, 64'(req1_ready), 64'(r1));
      chk({tag, " we"},     64'(we),         64'(w));
      chk({tag, " waddr"},  64'(waddr),      64'(wa));
      chk({tag, " wdata"},  64'(wdata),      64'(wd));
      chk({tag, " pend"},   64'(pend_mask),  64'(pm));
   endtask

   // Reference model: slots tagged with the cycle they were loaded in.
   logic        mv [2];
   logic [4:0]  ma [2];
   logic [31:0] md [2];
   int          ms [2];
   logic        mrr, mwe;
   logic [4:0]  mwa;
   logic [31:0] mwd;

   initial begin
      logic        h, v0, v1, g0, g1, er0, er1;
      logic [4:0]  a0, a1, ga;
      logic [31:0] d0, d1, gd, epm;

      tbl[0]  = mk(0,1,3,32'hDEADBEEF,0,0,0,     1,1,0,0,0,0);
      tbl[1]  = mk(0,0,0,0,0,0,0,                1,1,0,0,0,32'h8);
      tbl[2]  = mk(0,0,0,0,0,0,0,                1,1,1,3,32'hDEADBEEF,32'h8);
      tbl[3]  = mk(0,0,0,0,0,0,0,                1,1,0,3,32'hDEADBEEF,0);
      tbl[4]  = mk(0,1,5,32'h11,1,6,32'h22,      1,1,0,3,32'hDEADBEEF,0);
      tbl[5]  = mk(0,0,0,0,0,0,0,                1,0,0,3,32'hDEADBEEF,32'h60);
      tbl[6]  = mk(0,0,0,0,0,0,0,                1,1,1,5,32'h11,32'h60);
      tbl[7]  = mk(0,1,5,32'h11,1,6,32'h22,      1,1,1,6,32'h22,32'h40);
      tbl[8]  = mk(0,0,0,0,0,0,0,                0,1,0,6,32'h22,32'h60);
      tbl[9]  = mk(0,0,0,0,0,0,0,                1,1,1,6,32'h22,32'h60);
      tbl[10] = mk(0,0,0,0,0,0,0,                1,1,1,5,32'h11,32'h20);
      tbl[11] = mk(0,0,0,0,0,0,0,                1,1,0,5,32'h11,0);
      tbl[12] = mk(0,0,0,0,1,7,32'hAA,           1,1,0,5,32'h11,0);
      tbl[13] = mk(1,1,7,32'hBB,0,0,0,           1,0,0,5,32'h11,32'h80);
      tbl[14] = mk(0,0,0,0,0,0,0,                0,1,0,5,32'h11,32'h80);
      tbl[15] = mk(0,0,0,0,0,0,0,                1,1,1,7,32'hAA,32'h80);
      tbl[16] = mk(0,0,0,0,0,0,0,                1,1,1,7,32'hBB,32'h80);
      tbl[17] = mk(0,0,0,0,0,0,0,                1,1,0,7,32'hBB,0);
      tbl[18] = mk(0,1,0,32'hFFFFFFFF,0,0,0,     1,1,0,7,32'hBB,0);
      tbl[19] = mk(0,0,0,0,0,0,0,                1,1,0,7,32'hBB,0);
      tbl[20] = mk(0,0,0,0,0,0,0,                1,1,0,7,32'hBB,0);
      tbl[21] = mk(1,1,9,32'h99,1,10,32'h1010,   1,1,0,7,32'hBB,0);
      tbl[22] = mk(1,1,9,32'h99,1,10,32'h1010,   0,0,0,7,32'hBB,32'h600);
      tbl[23] = mk(1,1,9,32'h99,1,10,32'h1010,   0,0,0,7,32'hBB,32'h600);
      tbl[24] = mk(1,1,9,32'h99,1,10,32'h1010,   0,0,0,7,32'hBB,32'h600);
      tbl[25] = mk(0,0,0,0,0,0,0,                1,0,0,7,32'hBB,32'h600);
      tbl[26] = mk(0,0,0,0,0,0,0,                1,1,1,9,32'h99,32'h600);
      tbl[27] = mk(0,0,0,0,0,0,0,                1,1,1,10,32'h1010,32'h400);
      tbl[28] = mk(0,0,0,0,0,0,0,                1,1,0,10,32'h1010,0);

      rst = 1'b0;
      drive(0,0,0,0,0,0,0);
      #1;
      chk_outs("reset", 1, 1, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Directed vectors: inputs for the cycle, outputs seen in that cycle.
      for (int i = 0; i < 29; i++) begin
         @(negedge clk);
         drive(tbl[i].hold, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
         #1;
         chk_outs($sformatf("row%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].we, tbl[i].wa,
                  tbl[i].wd, tbl[i].pm);
      end
      chk("rf r7 final", 64'(tb_rf[7]), 64'h000000BB);

      // Reset mid-burst with both slots full.
      @(negedge clk);
      drive(1,1,12,32'h12,1,13,32'h13);
      @(negedge clk);
      drive(1,0,0,0,0,0,0);
      #1;
      chk("preload pend", 64'(pend_mask), 64'h3000);
      #2 rst = 1'b0;
      #1;
      chk_outs("mid reset", 1, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk_outs("held reset", 1, 1, 0, 0, 0, 0);
      rst = 1'b1;
      drive(0,0,0,0,0,0,0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk_outs($sformatf("post reset%0d", i), 1, 1, 0, 0, 0, 0);
      end

      // Random traffic against the model.
      for (int p = 0; p < 2; p++) begin mv[p] = 0; ma[p] = 0; md[p] = 0; ms[p] = 0; end
      mrr = 0; mwe = 0; mwa = 0; mwd = 0;
      for (int c = 0; c < 3000; c++) begin
         h  = ($urandom_range(0, 7) == 0);
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         a0 = 5'($urandom_range(0, 7));
         a1 = 5'($urandom_range(0, 7));
         d0 = $urandom;
         d1 = $urandom;
         @(negedge clk);
         drive(h, v0, a0, d0, v1, a1, d1);
         #1;
         g0 = 0; g1 = 0;
         if (!h) begin
            if (mv[0] && mv[1]) begin
               if (ms[0] < ms[1])      g0 = 1;
               else if (ms[1] < ms[0]) g1 = 1;
               else if (!mrr)          g0 = 1;
               else                    g1 = 1;
            end else if (mv[0]) g0 = 1;
            else if (mv[1])     g1 = 1;
         end
         er0 = !mv[0] || g0;
         er1 = !mv[1] || g1;
         epm = 0;
         for (int k = 1; k < 32; k++)
            if ((mv[0] && ma[0] == 5'(k)) || (mv[1] && ma[1] == 5'(k)) || (mwe && mwa == 5'(k)))
               epm[k] = 1'b1;
         chk_outs($sformatf("rnd%0d", c), er0, er1, mwe, mwa, mwd, epm);

         if (mv[0] && mv[1] && (g0 || g1)) mrr = g0;
         mwe = 0;
         if (g0 || g1) begin
            ga = g0 ? ma[0] : ma[1];
            gd = g0 ? md[0] : md[1];
            if (ga != 0) begin mwe = 1; mwa = ga; mwd = gd; end
         end
         if (g0) mv[0] = 0;
         if (g1) mv[1] = 0;
         if (v0 && er0) begin mv[0] = 1; ma[0] = a0; md[0] = d0; ms[0] = c; end
         if (v1 && er1) begin mv[1] = 1; ma[1] = a1; md[1] = d1; ms[1] = c; end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32×32 register file's single write port. It accepts write requests from two producers (port 0: ALU write-back, port 1: load write-back), buffers one request per port, and issues at most one write per cycle on the registered `we`/`waddr`/`wdata` outputs. Writes to r0 are dropped. It also publishes a pending-write mask so issue logic can detect RAW hazards against writes not yet committed.

## Interface
Parameters:
- `AW`, 5: register address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hold`  in  1  when 1, no grant is made; slots keep their contents; `we` = 0 next cycle.
- `req0_valid`, `req1_valid`  in  1 each  request present.
- `req0_ready`, `req1_ready`  out  1 each  request accepted on a cycle with valid & ready.
- `req0_addr`, `req1_addr`  in  AW each  destination register.
- `req0_data`, `req1_data`  in  DW each  write data.
- `we`  out  1  register-file write enable (registered).
- `waddr`  out  AW  register-file write address (registered).
- `wdata`  out  DW  register-file write data (registered).
- `pend_mask`  out  32  bit k = 1 while a write to rk is buffered or presented on `we`/`waddr`; bit 0 is always 0.

## Operation
- Each port has a one-entry slot: `v`, `addr`, `data`.
- `reqN_ready` = ~slotN.v | grantN.
  - Grant is derived only from registered state and `hold`, so there is no combinational path from valid to ready.
- Grant selection, evaluated every cycle with `hold` = 0:
  - One slot occupied: grant that slot.
  - Both occupied: grant the older slot.
  - Both loaded in the same cycle: the round-robin pointer decides. The pointer holds the port not granted last; its reset value is 0, so port 0 is preferred.
  - The round-robin pointer updates only on two-way contention.
- Age bit: set when a slot is loaded while the other slot stays occupied. This preserves arrival order for same-address writes across ports.
- Granted slot, nonzero addr: next cycle `we` = 1, `waddr`/`wdata` = slot contents; the slot is freed.
- Granted slot, addr = 0: the slot is freed and `we` = 0. The request is consumed silently.
- No grant: `we` = 0; `waddr`/`wdata` hold their last values.
- Freed slot with concurrent valid: the slot is refilled in the same cycle (full throughput of 1 write/cycle/port while the other port is idle).
- `pend_mask` is combinational from the slots plus the output register (`we` & `waddr`). Bit 0 is masked.

## Timing
- Reset (`rst` = 0, asynchronous): slots empty, age/round-robin pointer = 0, `we` = 0, `waddr` = 0, `wdata` = 0, `pend_mask` = 0, both readies = 1.
- Reset mid-operation discards all buffered writes. No write is issued during or after reset release until a new request arrives.
- Latency: request accepted at edge T → granted in cycle T → `we` high after edge T+1. The register file captures on the falling edge inside that same cycle.
- The pend bit for an address clears after the edge ending the `we` cycle, once the write is committed.
- Contention: two requests accepted on the same edge issue on consecutive cycles, port 0 first after reset, alternating thereafter.
- `hold` = 1 for N cycles delays issue by exactly N cycles. Readies drop once the slots are full.
- Integration: the register file's reset is active-high, so the top level drives it with `~rst`. Its read-enable is tied so reads remain valid while `we` = 1.

## Structure
- Shared package `regfile_pkg`: `REG_AW` = 5, `REG_DW` = 32, `NUM_REGS` = 32, `ZERO_REG` = 5'd0, and the slot record typedef (`v`, `addr`, `data`).
- Sub-module `wb_slot`: one-entry buffer with load/free and valid, instantiated twice.
- Arbitration, age, round-robin pointer, output register and `pend_mask` decode live in the top.

## Test plan
- Reset with `rst` = 0 mid-burst, slots full → all outputs 0, both readies 1; no `we` pulse after release.
- Port 0 only: addr 3 / 0xDEADBEEF accepted at T → `we` = 1, `waddr` = 3, `wdata` = 0xDEADBEEF in cycle T+1. `pend_mask`[3] is high T..T+1 and low after.
- Both valid on the same edge (p0: r5 = 0x11, p1: r6 = 0x22) → r5 issued first, r6 next cycle. Repeating the pair → r6 first.
- Same address, staggered: p1 writes r7 = 0xAA at T, p0 writes r7 = 0xBB at T+1 while p1 is blocked by `hold` → issue order 0xAA then 0xBB; a final read of r7 returns 0xBB.
- Write to r0 = 0xFFFFFFFF → ready handshake completes, `we` stays 0, `pend_mask` = 0.
- `hold` = 1 for 3 cycles with both slots full → readies 0, no `we`. After release, two writes issue on consecutive cycles.
